ula_seq: RTL and testbench
==========================

Name: ula_seq

Overview:
- Issue/writeback sequencer for the 6-bit ULA; sits on the ULA's input side.
- Holds a small operand register file and accepts instruction words through a valid/ready handshake.
- Drives the ULA select and operand lines, captures O/Cout/Zero, writes the result back to the register file and presents it on a result handshake.
- A host loads operands through a direct load port, then streams operations.

Parameters:
- DW, 6, data width; matches the ULA operand/result width.
- AW, 2, register address width; register file depth = 2**AW (4 registers).
- CW, 8, width of the completed-operation counter.

Ports:
- CLK  in  1  clock, rising edge
- R  in  1  reset, asynchronous, active-high
- IN_VALID  in  1  instruction offered
- IN_READY  out  1  sequencer can accept an instruction
- IN_INSTR  in  4+3*AW (10)  fields: [9:6] op, [5:4] rd, [3:2] ra, [1:0] rb
- LD_EN  in  1  direct register write enable
- LD_ADDR  in  AW  direct write address
- LD_DATA  in  DW  direct write data
- S  out  4  ULA operation select
- A  out  DW  ULA operand A
- B  out  DW  ULA operand B
- O  in  DW  ULA result
- Cout  in  1  ULA carry flag
- Zero  in  1  ULA zero flag
- RES_VALID  out  1  result available
- RES_READY  in  1  consumer takes result
- RES_DATA  out  DW  captured result
- RES_COUT  out  1  captured Cout
- RES_ZERO  out  1  captured Zero
- BUSY  out  1  state != IDLE
- OPCNT  out  CW  completed operations, wraps modulo 2**CW

Behaviour:
- Reset (R=1, asynchronous):
  - state=IDLE; all registers 0.
  - S, A, B, RES_DATA, RES_COUT, RES_ZERO, OPCNT all 0.
  - RES_VALID=0, BUSY=0.
  - IN_READY=1 while in IDLE; this includes while R is held.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
  - IDLE: IN_READY=1. On IN_VALID&IN_READY at a clock edge:
    - latch op into S, rf[ra] into A, rf[rb] into B, rd into an internal register;
    - go to EXEC.
  - EXEC: one cycle only. S/A/B are stable registered outputs, and the ULA is combinational.
    - At the closing edge: RES_DATA<=O, RES_COUT<=Cout, RES_ZERO<=Zero, rf[rd]<=O, OPCNT<=OPCNT+1.
    - Go to RESP.
  - RESP: RES_VALID=1. RES_* are held stable until RES_READY=1 at an edge, then go to IDLE.
    - The RESP -> IDLE edge does not accept a new instruction, because IN_READY=0 in RESP.
- IN_READY = (state==IDLE), combinational from state. IN_INSTR is ignored whenever IN_READY=0.
- Latency: accept edge t -> RES_VALID=1 from t+2. Minimum issue interval is 3 cycles with RES_READY tied high.
- S/A/B hold their last issued values outside EXEC; they change only on the accept edge.
- Operand read semantics:
  - rf is read before write on the accept edge.
  - An LD_EN write to ra or rb in the same cycle yields the old value to A/B; the new value lands in rf.
- Register write priority:
  - LD_EN writes at any state.
  - On the EXEC closing edge, if LD_EN and LD_ADDR==rd, the ULA writeback wins and the LD write is dropped.
- Aliasing: ra==rb and rd==ra/rb are legal. Writeback overwrites the source after the operands have been sampled.
- Widths:
  - O/Cout/Zero are captured verbatim; the sequencer performs no arithmetic on the data.
  - OPCNT is modulo 2**CW: 255+1 -> 0.
- Reset mid-operation:
  - any state returns to IDLE immediately;
  - RES_VALID drops asynchronously;
  - the in-flight result is discarded, and rf, OPCNT and the RES_* values are cleared.
- All 16 op encodings are passed through unchanged. The sequencer does not decode op.

Test Plan:
- LD r0=40, r1=30; instr op=0000 rd=2 ra=0 rb=1 -> RES_VALID at t+2, RES_DATA=6, RES_COUT=1, RES_ZERO=0; rf[2]=6; OPCNT=1.
- LD r0=5, r1=5; op=0001 rd=3 ra=0 rb=1 -> RES_DATA=0, RES_COUT=0, RES_ZERO=1; S=0001, A=5, B=5 held after completion.
- LD r0=63; op=0100 rd=0 ra=0 -> RES_DATA=0, RES_COUT=1, RES_ZERO=1, rf[0]=0. A following op=1110 ra=0 rd=1 returns 0.
- Backpressure:
  - hold RES_READY=0 for 5 cycles with IN_VALID=1 -> RES_VALID and RES_* stable, IN_READY=0, no second issue;
  - RES_READY=1 -> IDLE next cycle.
- Collision: at the EXEC edge drive LD_EN=1, LD_ADDR=rd, LD_DATA=17 -> rf[rd] holds the ULA result, not 17. An LD to ra on the accept edge -> A gets the old value.
- Assert R during EXEC -> RES_VALID=0, BUSY=0, OPCNT=0, rf all 0 without waiting for a clock; IN_READY=1. After release, normal issue resumes.

Source files
------------

// File: rtl/ula_seq_if.sv
// Bundle of every non-clock signal between the ULA sequencer and its environment
// (host instruction/load ports, ULA operand/result lines, result handshake).
interface ula_seq_if #(
    parameter int DW = 6,
    parameter int AW = 2,
    parameter int CW = 8
);
    logic              IN_VALID;
    logic              IN_READY;
    logic [3+3*AW:0]   IN_INSTR;
    logic              LD_EN;
    logic [AW-1:0]     LD_ADDR;
    logic [DW-1:0]     LD_DATA;
    logic [3:0]        S;
    logic [DW-1:0]     A;
    logic [DW-1:0]     B;
    logic [DW-1:0]     O;
    logic              Cout;
    logic              Zero;
    logic              RES_VALID;
    logic              RES_READY;
    logic [DW-1:0]     RES_DATA;
    logic              RES_COUT;
    logic              RES_ZERO;
    logic              BUSY;
    logic [CW-1:0]     OPCNT;

    // The environment side: host plus the combinational ULA itself.
    modport master (
        output IN_VALID, IN_INSTR, LD_EN, LD_ADDR, LD_DATA, O, Cout, Zero, RES_READY,
        input  IN_READY, S, A, B, RES_VALID, RES_DATA, RES_COUT, RES_ZERO, BUSY, OPCNT
    );

    modport slave (
        input  IN_VALID, IN_INSTR, LD_EN, LD_ADDR, LD_DATA, O, Cout, Zero, RES_READY,
        output IN_READY, S, A, B, RES_VALID, RES_DATA, RES_COUT, RES_ZERO, BUSY, OPCNT
    );
endinterface

// File: rtl/ula_seq.sv
// Issue/writeback sequencer for the 6-bit ULA: register file, instruction handshake,
// registered ULA drive, result capture and writeback, result handshake.
module ula_seq #(
    parameter int DW = 6,
    parameter int AW = 2,
    parameter int CW = 8
) (
    input logic      CLK,
    input logic      R,
    ula_seq_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam int IW   = 4 + 3 * AW;
    localparam int NREG = 2 ** AW;

    logic [1:0]    state;
    logic [DW-1:0] rf [NREG];
    logic [AW-1:0] rd_q;
    logic [3:0]    s_q;
    logic [DW-1:0] a_q;
    logic [DW-1:0] b_q;
    logic [DW-1:0] res_data;
    logic          res_cout;
    logic          res_zero;
    logic [CW-1:0] opcnt;

    logic [3:0]    op_f;
    logic [AW-1:0] rd_f;
    logic [AW-1:0] ra_f;
    logic [AW-1:0] rb_f;
    logic          accept;

    assign op_f   = bus.IN_INSTR[IW-1 -: 4];
    assign rd_f   = bus.IN_INSTR[3*AW-1 -: AW];
    assign ra_f   = bus.IN_INSTR[2*AW-1 -: AW];
    assign rb_f   = bus.IN_INSTR[AW-1:0];
    assign accept = bus.IN_VALID && (state == IDLE);

    // The EXEC writeback is placed after the load-port write so that it wins a same-address collision.
    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            state    <= IDLE;
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
            rd_q     <= '0;
            s_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_data <= '0;
            res_cout <= 1'b0;
            res_zero <= 1'b0;
            opcnt    <= '0;
        end else begin
            if (bus.LD_EN) rf[bus.LD_ADDR] <= bus.LD_DATA;
            case (state)
                IDLE: begin
                    if (accept) begin
                        s_q   <= op_f;
                        a_q   <= rf[ra_f];
                        b_q   <= rf[rb_f];
                        rd_q  <= rd_f;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    res_data <= bus.O;
                    res_cout <= bus.Cout;
                    res_zero <= bus.Zero;
                    rf[rd_q] <= bus.O;
                    opcnt    <= opcnt + CW'(1);
                    state    <= RESP;
                end
                RESP: begin
                    if (bus.RES_READY) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.IN_READY  = (state == IDLE);
    assign bus.RES_VALID = (state == RESP);
    assign bus.BUSY      = (state != IDLE);
    assign bus.S         = s_q;
    assign bus.A         = a_q;
    assign bus.B         = b_q;
    assign bus.RES_DATA  = res_data;
    assign bus.RES_COUT  = res_cout;
    assign bus.RES_ZERO  = res_zero;
    assign bus.OPCNT     = opcnt;
endmodule

// File: tb/tb_ula_seq.sv
// Self-checking bench for ula_seq: a behavioural ULA drives O/Cout/Zero and a
// register-file/counter model predicts every result the sequencer reports.
module tb_ula_seq;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    logic [5:0] rf_m [4];
    int   opcnt_m;

    always #5 clk = ~clk;

    ula_seq_if #(.DW(6), .AW(2), .CW(8)) bus();
    ula_seq #(.DW(6), .AW(2), .CW(8)) dut (.CLK(clk), .R(rst), .bus(bus));

    // Stand-in ULA: returns {cout, zero, result}.
    function automatic logic [7:0] ula_f(input logic [3:0] op, input logic [5:0] a, input logic [5:0] b);
        logic [6:0] t;
        case (op)
            4'd0:  t = {1'b0, a} + {1'b0, b};
            4'd1:  t = {(a < b), a - b};
            4'd4:  t = {1'b0, a} + 7'd1;
            4'd14: t = {1'b0, a};
            default: t = {op[0], a ^ b ^ {op, 2'b00}};
        endcase
        return {t[6], (t[5:0] == 6'd0), t[5:0]};
    endfunction

    always_comb {bus.Cout, bus.Zero, bus.O} = ula_f(bus.S, bus.A, bus.B);

    task automatic model_op(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] ra,
                            input logic [1:0] rb, output logic [7:0] e);
        e = ula_f(op, rf_m[ra], rf_m[rb]);
        rf_m[rd] = e[5:0];
        opcnt_m++;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) rf_m[i] = 6'd0;
        opcnt_m = 0;
    endtask

    task automatic ld(input logic [1:0] addr, input logic [5:0] data);
        bus.LD_EN = 1'b1; bus.LD_ADDR = addr; bus.LD_DATA = data;
        @(posedge clk); #1;
        bus.LD_EN = 1'b0;
        rf_m[addr] = data;
    endtask

    // Issues one instruction and returns what the sequencer produced; lat counts edges after accept.
    task automatic send_op(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] ra, input logic [1:0] rb,
                           output logic [5:0] d, output logic c, output logic z, output int lat,
                           output logic [5:0] a_seen, output logic [5:0] b_seen);
        int w;
        bus.IN_INSTR = {op, rd, ra, rb};
        bus.IN_VALID = 1'b1;
        w = 0;
        while (!bus.IN_READY && w < 20) begin @(posedge clk); #1; w++; end
        @(posedge clk); #1;
        bus.IN_VALID = 1'b0;
        a_seen = bus.A; b_seen = bus.B;
        lat = 0;
        while (!bus.RES_VALID && lat < 20) begin @(posedge clk); #1; lat++; end
        d = bus.RES_DATA; c = bus.RES_COUT; z = bus.RES_ZERO;
        bus.RES_READY = 1'b1;
        @(posedge clk); #1;
        bus.RES_READY = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (bus.IN_READY !== 1'b1) begin errors++; $display("[TB] FAIL rst_in_ready got %0b expected 1", bus.IN_READY); end
        checks++; if (bus.RES_VALID !== 1'b0) begin errors++; $display("[TB] FAIL rst_res_valid got %0b expected 0", bus.RES_VALID); end
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy got %0b expected 0", bus.BUSY); end
        checks++; if ({bus.S, bus.A, bus.B} !== 16'd0) begin errors++; $display("[TB] FAIL rst_sab got %h expected 0", {bus.S, bus.A, bus.B}); end
        checks++; if ({bus.RES_DATA, bus.RES_COUT, bus.RES_ZERO} !== 8'd0) begin errors++; $display("[TB] FAIL rst_res got %h expected 0", {bus.RES_DATA, bus.RES_COUT, bus.RES_ZERO}); end
        checks++; if (bus.OPCNT !== 8'd0) begin errors++; $display("[TB] FAIL rst_opcnt got %0d expected 0", bus.OPCNT); end
    endtask

    task automatic test_add();
        logic [5:0] d, a, b; logic c, z; int lat; logic [7:0] e;
        ld(2'd0, 6'd40); ld(2'd1, 6'd30);
        model_op(4'd0, 2'd2, 2'd0, 2'd1, e);
        send_op(4'd0, 2'd2, 2'd0, 2'd1, d, c, z, lat, a, b);
        checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL add_latency got %0d expected 1", lat); end
        checks++; if ({d, c, z} !== {6'd6, 1'b1, 1'b0}) begin errors++; $display("[TB] FAIL add_result got %0d/%0b/%0b expected 6/1/0", d, c, z); end
        checks++; if (bus.OPCNT !== 8'd1) begin errors++; $display("[TB] FAIL add_opcnt got %0d expected 1", bus.OPCNT); end
        model_op(4'd14, 2'd3, 2'd2, 2'd2, e);
        send_op(4'd14, 2'd3, 2'd2, 2'd2, d, c, z, lat, a, b);
        checks++; if (a !== 6'd6) begin errors++; $display("[TB] FAIL add_writeback got %0d expected 6", a); end
    endtask

    task automatic test_sub_zero();
        logic [5:0] d, a, b; logic c, z; int lat; logic [7:0] e;
        ld(2'd0, 6'd5); ld(2'd1, 6'd5);
        model_op(4'd1, 2'd3, 2'd0, 2'd1, e);
        send_op(4'd1, 2'd3, 2'd0, 2'd1, d, c, z, lat, a, b);
        checks++; if ({d, c, z} !== {6'd0, 1'b0, 1'b1}) begin errors++; $display("[TB] FAIL sub_result got %0d/%0b/%0b expected 0/0/1", d, c, z); end
        checks++; if ({bus.S, bus.A, bus.B} !== {4'd1, 6'd5, 6'd5}) begin errors++; $display("[TB] FAIL sub_hold_sab got %h expected %h", {bus.S, bus.A, bus.B}, {4'd1, 6'd5, 6'd5}); end
    endtask

    task automatic test_alias();
        logic [5:0] d, a, b; logic c, z; int lat; logic [7:0] e;
        ld(2'd0, 6'd63);
        model_op(4'd4, 2'd0, 2'd0, 2'd0, e);
        send_op(4'd4, 2'd0, 2'd0, 2'd0, d, c, z, lat, a, b);
        checks++; if ({d, c, z} !== {6'd0, 1'b1, 1'b1}) begin errors++; $display("[TB] FAIL alias_inc got %0d/%0b/%0b expected 0/1/1", d, c, z); end
        model_op(4'd14, 2'd1, 2'd0, 2'd0, e);
        send_op(4'd14, 2'd1, 2'd0, 2'd0, d, c, z, lat, a, b);
        checks++; if (d !== 6'd0) begin errors++; $display("[TB] FAIL alias_readback got %0d expected 0", d); end
    endtask

    task automatic test_backpressure();
        logic [7:0] e;
        ld(2'd0, 6'd12); ld(2'd1, 6'd7);
        model_op(4'd0, 2'd3, 2'd0, 2'd1, e);
        bus.IN_INSTR = {4'd0, 2'd3, 2'd0, 2'd1};
        bus.IN_VALID = 1'b1;
        @(posedge clk); #1;
        bus.IN_INSTR = {4'd9, 2'd0, 2'd2, 2'd2};
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({bus.RES_VALID, bus.IN_READY, bus.RES_DATA, bus.S} !== {1'b1, 1'b0, 6'd19, 4'd0}) begin
                errors++;
                $display("[TB] FAIL bp_hold cycle %0d got valid=%0b ready=%0b data=%0d S=%0d expected 1/0/19/0",
                         i, bus.RES_VALID, bus.IN_READY, bus.RES_DATA, bus.S);
            end
            @(posedge clk); #1;
        end
        bus.RES_READY = 1'b1;
        @(posedge clk); #1;
        bus.IN_VALID = 1'b0;
        bus.RES_READY = 1'b0;
        checks++; if ({bus.IN_READY, bus.BUSY, bus.RES_VALID} !== 3'b100) begin errors++; $display("[TB] FAIL bp_release got %b expected 100", {bus.IN_READY, bus.BUSY, bus.RES_VALID}); end
        checks++; if ({bus.S, bus.OPCNT} !== {4'd0, 8'(opcnt_m)}) begin errors++; $display("[TB] FAIL bp_no_second_issue got S=%0d cnt=%0d expected 0/%0d", bus.S, bus.OPCNT, opcnt_m); end
    endtask

    task automatic test_collision();
        logic [5:0] d, a, b; logic c, z; int lat; logic [7:0] e;
        ld(2'd2, 6'd10); ld(2'd3, 6'd20);
        bus.IN_INSTR = {4'd0, 2'd1, 2'd2, 2'd3};
        bus.IN_VALID = 1'b1;
        bus.LD_EN = 1'b1; bus.LD_ADDR = 2'd2; bus.LD_DATA = 6'd9;
        @(posedge clk); #1;
        bus.IN_VALID = 1'b0;
        checks++; if ({bus.A, bus.B} !== {6'd10, 6'd20}) begin errors++; $display("[TB] FAIL col_read_old got A=%0d B=%0d expected 10/20", bus.A, bus.B); end
        bus.LD_ADDR = 2'd1; bus.LD_DATA = 6'd17;
        @(posedge clk); #1;
        bus.LD_EN = 1'b0;
        rf_m[2] = 6'd9; rf_m[1] = 6'd30; opcnt_m++;
        checks++; if ({bus.RES_VALID, bus.RES_DATA} !== {1'b1, 6'd30}) begin errors++; $display("[TB] FAIL col_result got %0b/%0d expected 1/30", bus.RES_VALID, bus.RES_DATA); end
        bus.RES_READY = 1'b1;
        @(posedge clk); #1;
        bus.RES_READY = 1'b0;
        model_op(4'd14, 2'd0, 2'd1, 2'd2, e);
        send_op(4'd14, 2'd0, 2'd1, 2'd2, d, c, z, lat, a, b);
        checks++; if (a !== 6'd30) begin errors++; $display("[TB] FAIL col_wb_wins got %0d expected 30", a); end
        checks++; if (b !== 6'd9) begin errors++; $display("[TB] FAIL col_ld_lands got %0d expected 9", b); end
    endtask

    task automatic test_back_to_back();
        int cnt;
        cnt = 0;
        bus.IN_INSTR = {4'd14, 2'd0, 2'd0, 2'd0};
        bus.IN_VALID = 1'b1;
        bus.RES_READY = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (bus.IN_READY) cnt++;
            @(posedge clk); #1;
        end
        bus.IN_VALID = 1'b0;
        bus.RES_READY = 1'b0;
        opcnt_m += 4;
        checks++; if (cnt !== 4) begin errors++; $display("[TB] FAIL b2b_issues got %0d expected 4", cnt); end
        checks++; if (bus.OPCNT !== 8'(opcnt_m)) begin errors++; $display("[TB] FAIL b2b_opcnt got %0d expected %0d", bus.OPCNT, 8'(opcnt_m)); end
    endtask

    task automatic test_random();
        logic [5:0] d, a, b; logic c, z; int lat; logic [7:0] e;
        logic [3:0] op; logic [1:0] rd, ra, rb;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(1, 0) == 1) ld(2'($urandom_range(3, 0)), 6'($urandom_range(63, 0)));
            op = 4'($urandom_range(15, 0));
            rd = 2'($urandom_range(3, 0));
            ra = 2'($urandom_range(3, 0));
            rb = 2'($urandom_range(3, 0));
            model_op(op, rd, ra, rb, e);
            send_op(op, rd, ra, rb, d, c, z, lat, a, b);
            checks++;
            if ({lat[1:0], c, z, d} !== {2'd1, e}) begin
                errors++;
                $display("[TB] FAIL rand_op %0d op=%0d got lat=%0d c=%0b z=%0b d=%0d expected lat=1 c=%0b z=%0b d=%0d",
                         i, op, lat, c, z, d, e[7], e[6], e[5:0]);
            end
        end
        checks++; if (bus.OPCNT !== 8'(opcnt_m)) begin errors++; $display("[TB] FAIL rand_opcnt got %0d expected %0d", bus.OPCNT, 8'(opcnt_m)); end
    endtask

    task automatic test_opcnt_wrap();
        logic [5:0] d, a, b; logic c, z; int lat; logic [7:0] e;
        int n;
        n = 256 - (opcnt_m % 256);
        for (int i = 0; i < n; i++) begin
            model_op(4'd2, 2'd3, 2'd0, 2'd1, e);
            send_op(4'd2, 2'd3, 2'd0, 2'd1, d, c, z, lat, a, b);
        end
        checks++; if (bus.OPCNT !== 8'd0) begin errors++; $display("[TB] FAIL opcnt_wrap got %0d expected 0", bus.OPCNT); end
        checks++; if (d !== e[5:0]) begin errors++; $display("[TB] FAIL wrap_last_result got %0d expected %0d", d, e[5:0]); end
    endtask

    task automatic test_reset_mid();
        logic [5:0] d, a, b; logic c, z; int lat;
        ld(2'd1, 6'd44);
        bus.IN_INSTR = {4'd0, 2'd3, 2'd1, 2'd1};
        bus.IN_VALID = 1'b1;
        @(posedge clk); #1;
        bus.IN_VALID = 1'b0;
        checks++; if (bus.BUSY !== 1'b1) begin errors++; $display("[TB] FAIL mid_busy_pre got %0b expected 1", bus.BUSY); end
        #1 rst = 1'b1;
        #1;
        checks++; if ({bus.RES_VALID, bus.BUSY, bus.IN_READY} !== 3'b001) begin errors++; $display("[TB] FAIL mid_async_state got %b expected 001", {bus.RES_VALID, bus.BUSY, bus.IN_READY}); end
        checks++; if ({bus.OPCNT, bus.RES_DATA, bus.A} !== 20'd0) begin errors++; $display("[TB] FAIL mid_async_clear got cnt=%0d data=%0d A=%0d expected 0", bus.OPCNT, bus.RES_DATA, bus.A); end
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        send_op(4'd14, 2'd0, 2'd1, 2'd3, d, c, z, lat, a, b);
        opcnt_m++;
        checks++; if ({a, d, z} !== {6'd0, 6'd0, 1'b1}) begin errors++; $display("[TB] FAIL mid_rf_cleared got A=%0d d=%0d z=%0b expected 0/0/1", a, d, z); end
        checks++; if (bus.OPCNT !== 8'd1) begin errors++; $display("[TB] FAIL mid_resume_opcnt got %0d expected 1", bus.OPCNT); end
    endtask

    initial begin
        rst = 1'b1;
        bus.IN_VALID = 1'b0; bus.IN_INSTR = '0;
        bus.LD_EN = 1'b0; bus.LD_ADDR = '0; bus.LD_DATA = '0;
        bus.RES_READY = 1'b0;
        model_clear();
        #12;
        test_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        test_add();
        test_sub_zero();
        test_alias();
        test_backpressure();
        test_collision();
        test_back_to_back();
        test_random();
        test_opcnt_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
